// File: rtl/relu_maxpool_2x2.sv
// 2x2 stride-2 per-lane max-pool over a raster activation stream.
// Row-pair partial maxima for even rows are parked in a half-width line buffer.
module relu_maxpool_2x2 #(
    parameter int unsigned LANES   = 32,
    parameter int unsigned DW      = 8,
    parameter int unsigned MAX_COL = 256,
    parameter int unsigned CW      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [CW-1:0]         i_fm_col,
    input  logic [CW-1:0]         i_fm_row,
    input  logic                  i_valid,
    input  logic [LANES*DW-1:0]   i_data,
    output logic                  o_valid,
    output logic [LANES*DW-1:0]   o_data,
    output logic                  o_done,
    output logic                  o_busy,
    output logic                  o_err
);

    localparam int unsigned DATA_W = LANES * DW;
    localparam int unsigned DEPTH  = MAX_COL / 2;
    localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e              state_q;
    logic [CW-1:0]       cfg_col_q;
    logic [CW-1:0]       cfg_row_q;
    logic [CW-1:0]       col_cnt_q;
    logic [CW-1:0]       row_cnt_q;
    logic [DATA_W-1:0]   hold_q;
    logic [DATA_W-1:0]   rd_q;
    logic [DATA_W-1:0]   linebuf [DEPTH];

    logic                cfg_ok_c;
    logic                beat_c;
    logic                col_odd_c;
    logic                row_odd_c;
    logic                last_col_c;
    logic                last_row_c;
    logic [AW-1:0]       addr_c;
    logic [DATA_W-1:0]   pair_c;
    logic [DATA_W-1:0]   pool_c;

    function automatic logic [DW-1:0] umax(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Config legality, beat decode and position flags
    always_comb begin
        cfg_ok_c   = (i_fm_col != '0) && !i_fm_col[0] && (i_fm_col <= CW'(MAX_COL))
                  && (i_fm_row != '0) && !i_fm_row[0];
        beat_c     = (state_q == ST_RUN) && i_valid;
        col_odd_c  = col_cnt_q[0];
        row_odd_c  = row_cnt_q[0];
        last_col_c = (col_cnt_q == (cfg_col_q - CW'(1)));
        last_row_c = (row_cnt_q == (cfg_row_q - CW'(1)));
        addr_c     = AW'(col_cnt_q >> 1);
    end

    // Lanewise unsigned max: horizontal pair, then against the stored upper-row pair
    always_comb begin
        pair_c = '0;
        pool_c = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            pair_c[DW*k +: DW] = umax(hold_q[DW*k +: DW], i_data[DW*k +: DW]);
            pool_c[DW*k +: DW] = umax(pair_c[DW*k +: DW], rd_q[DW*k +: DW]);
        end
    end

    // Line buffer: written on even rows, read ahead on the even column of odd rows
    always_ff @(posedge clk) begin
        if (beat_c && col_odd_c && !row_odd_c) begin
            linebuf[addr_c] <= pair_c;
        end
        if (beat_c && !col_odd_c && row_odd_c) begin
            rd_q <= linebuf[addr_c];
        end
    end

    // Control FSM, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cfg_col_q <= '0;
            cfg_row_q <= '0;
            col_cnt_q <= '0;
            row_cnt_q <= '0;
            hold_q    <= '0;
            o_valid   <= 1'b0;
            o_data    <= '0;
            o_done    <= 1'b0;
            o_busy    <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            o_done  <= 1'b0;
            o_err   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        if (cfg_ok_c) begin
                            cfg_col_q <= i_fm_col;
                            cfg_row_q <= i_fm_row;
                            col_cnt_q <= '0;
                            row_cnt_q <= '0;
                            state_q   <= ST_RUN;
                            o_busy    <= 1'b1;
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (i_valid) begin
                        if (!col_odd_c) begin
                            hold_q <= i_data;
                        end else if (row_odd_c) begin
                            o_data  <= pool_c;
                            o_valid <= 1'b1;
                        end
                        if (last_col_c) begin
                            col_cnt_q <= '0;
                            row_cnt_q <= row_cnt_q + CW'(1);
                            if (last_row_c) begin
                                state_q <= ST_IDLE;
                                o_busy  <= 1'b0;
                                o_done  <= 1'b1;
                            end
                        end else begin
                            col_cnt_q <= col_cnt_q + CW'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_relu_maxpool_2x2.sv
// Directed bench for relu_maxpool_2x2: config table plus frame sequences.
module tb_relu_maxpool_2x2;

    localparam int unsigned LANES  = 32;
    localparam int unsigned DW     = 8;
    localparam int unsigned CW     = 16;
    localparam int unsigned DATA_W = LANES * DW;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_start;
    logic [CW-1:0]     i_fm_col;
    logic [CW-1:0]     i_fm_row;
    logic              i_valid;
    logic [DATA_W-1:0] i_data;
    logic              o_valid;
    logic [DATA_W-1:0] o_data;
    logic              o_done;
    logic              o_busy;
    logic              o_err;

    relu_maxpool_2x2 dut (
        .clk      (clk),
        .rst      (rst),
        .i_start  (i_start),
        .i_fm_col (i_fm_col),
        .i_fm_row (i_fm_row),
        .i_valid  (i_valid),
        .i_data   (i_data),
        .o_valid  (o_valid),
        .o_data   (o_data),
        .o_done   (o_done),
        .o_busy   (o_busy),
        .o_err    (o_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output capture, sampled mid-cycle
    logic [DATA_W-1:0] out_q[$];
    int                outcyc_q[$];
    bit                outdone_q[$];
    int                done_cnt = 0;
    always @(negedge clk) begin
        if (o_valid) begin
            out_q.push_back(o_data);
            outcyc_q.push_back(cyc);
            outdone_q.push_back(o_done);
        end
        if (o_done) done_cnt <= done_cnt + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int expcyc_q[$];

    typedef struct {
        logic [CW-1:0] col;
        logic [CW-1:0] row;
        logic          exp_err;
    } cfg_vec_t;
    cfg_vec_t cfg_tab[8];

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] gen(input int mode, input int idx);
        logic [DATA_W-1:0] p;
        int t[3][4];
        t = '{'{1, 9, 4, 2}, '{3, 1, 2, 0}, '{10, 20, 30, 40}};
        p = '0;
        case (mode)
            0: p[7:0] = 8'(idx);
            1: for (int k = 0; k < int'(LANES); k++) p[DW*k +: DW] = 8'((idx * 3 + k) % 128);
            default: for (int k = 0; k < int'(LANES); k++) p[DW*k +: DW] = 8'(t[mode-2][idx]);
        endcase
        return p;
    endfunction

    function automatic logic [DATA_W-1:0] splat(input int v);
        logic [DATA_W-1:0] p;
        for (int k = 0; k < int'(LANES); k++) p[DW*k +: DW] = 8'(v);
        return p;
    endfunction

    task automatic start_frame(input int col, input int row);
        i_fm_col = CW'(col);
        i_fm_row = CW'(row);
        i_start  = 1'b1;
        tick();
        i_start  = 1'b0;
    endtask

    task automatic run_frame(input int col, input int mode, input int gap, input int nbeats);
        expcyc_q.delete();
        for (int idx = 0; idx < nbeats; idx++) begin
            i_valid = 1'b1;
            i_data  = gen(mode, idx);
            tick();
            i_valid = 1'b0;
            if (((idx % col) % 2 == 1) && ((idx / col) % 2 == 1)) expcyc_q.push_back(cyc);
            if (idx != nbeats - 1) repeat (gap) tick();
        end
    endtask

    // Software 2x2 max model over the generated frame
    task automatic check_frame(input string tag, input int col, input int row, input int mode, input int obase);
        int n;
        logic [DATA_W-1:0] e, px;
        n = (col / 2) * (row / 2);
        check({tag, "_count"}, DATA_W'(out_q.size() - obase), DATA_W'(n));
        for (int i = 0; i < n && (obase + i) < out_q.size(); i++) begin
            int r0, c0;
            r0 = (i / (col / 2)) * 2;
            c0 = (i % (col / 2)) * 2;
            e = '0;
            for (int d = 0; d < 4; d++) begin
                px = gen(mode, (r0 + d / 2) * col + c0 + d % 2);
                for (int k = 0; k < int'(LANES); k++)
                    if (px[DW*k +: DW] > e[DW*k +: DW]) e[DW*k +: DW] = px[DW*k +: DW];
            end
            check($sformatf("%s_data%0d", tag, i), out_q[obase+i], e);
            if (i < expcyc_q.size())
                check($sformatf("%s_lat%0d", tag, i), DATA_W'(outcyc_q[obase+i]), DATA_W'(expcyc_q[i]));
            check($sformatf("%s_done%0d", tag, i), DATA_W'(outdone_q[obase+i]), DATA_W'(i == n - 1));
        end
    endtask

    initial begin
        int ob, db;
        logic [DATA_W-1:0] exp4[4];
        cfg_tab[0] = '{col: 16'd4,   row: 16'd4, exp_err: 1'b0};
        cfg_tab[1] = '{col: 16'd3,   row: 16'd4, exp_err: 1'b1};
        cfg_tab[2] = '{col: 16'd0,   row: 16'd4, exp_err: 1'b1};
        cfg_tab[3] = '{col: 16'd258, row: 16'd2, exp_err: 1'b1};
        cfg_tab[4] = '{col: 16'd4,   row: 16'd3, exp_err: 1'b1};
        cfg_tab[5] = '{col: 16'd4,   row: 16'd0, exp_err: 1'b1};
        cfg_tab[6] = '{col: 16'd256, row: 16'd2, exp_err: 1'b0};
        cfg_tab[7] = '{col: 16'd2,   row: 16'd2, exp_err: 1'b0};
        exp4[0] = DATA_W'(5);
        exp4[1] = DATA_W'(7);
        exp4[2] = DATA_W'(13);
        exp4[3] = DATA_W'(15);

        rst = 1'b1; i_start = 1'b0; i_fm_col = '0; i_fm_row = '0; i_valid = 1'b0; i_data = '0;
        repeat (2) tick();
        check("rst_valid", DATA_W'(o_valid), '0);
        check("rst_data",  o_data, '0);
        check("rst_done",  DATA_W'(o_done), '0);
        check("rst_busy",  DATA_W'(o_busy), '0);
        check("rst_err",   DATA_W'(o_err), '0);
        rst = 1'b0;
        tick();

        // Config legality table
        foreach (cfg_tab[j]) begin
            start_frame(int'(cfg_tab[j].col), int'(cfg_tab[j].row));
            check($sformatf("cfg%0d_err", j),  DATA_W'(o_err),  DATA_W'(cfg_tab[j].exp_err));
            check($sformatf("cfg%0d_busy", j), DATA_W'(o_busy), DATA_W'(!cfg_tab[j].exp_err));
            rst = 1'b1; tick(); rst = 1'b0; tick();
        end

        // 4x4 contiguous
        ob = out_q.size(); db = done_cnt;
        start_frame(4, 4);
        run_frame(4, 0, 0, 16);
        repeat (3) tick();
        check_frame("f4", 4, 4, 0, ob);
        for (int i = 0; i < 4 && (ob + i) < out_q.size(); i++)
            check($sformatf("f4_hand%0d", i), out_q[ob+i], exp4[i]);
        check("f4_donecnt", DATA_W'(done_cnt - db), DATA_W'(1));
        check("f4_busy_end", DATA_W'(o_busy), '0);

        // 4x4 gapped 1-on/2-off
        ob = out_q.size();
        start_frame(4, 4);
        run_frame(4, 0, 2, 16);
        repeat (3) tick();
        check_frame("f4g", 4, 4, 0, ob);
        for (int i = 0; i < 4 && (ob + i) < out_q.size(); i++)
            check($sformatf("f4g_hand%0d", i), out_q[ob+i], exp4[i]);

        // Full-width 256x2
        ob = out_q.size();
        start_frame(256, 2);
        run_frame(256, 1, 0, 512);
        repeat (3) tick();
        check_frame("f256", 256, 2, 1, ob);

        // Illegal config then beats: nothing comes out
        ob = out_q.size();
        start_frame(3, 4);
        check("bad_err", DATA_W'(o_err), DATA_W'(1));
        check("bad_busy", DATA_W'(o_busy), '0);
        run_frame(2, 0, 0, 4);
        repeat (3) tick();
        check("bad_err_pulse", DATA_W'(o_err), '0);
        check("bad_noout", DATA_W'(out_q.size() - ob), '0);

        // Reset mid-frame right as the first window is emitted
        start_frame(4, 4);
        run_frame(4, 0, 0, 6);
        check("mid_valid_pre", DATA_W'(o_valid), DATA_W'(1));
        rst = 1'b1;
        #1;
        check("mid_valid", DATA_W'(o_valid), '0);
        check("mid_data",  o_data, '0);
        check("mid_busy",  DATA_W'(o_busy), '0);
        tick();
        rst = 1'b0;
        tick();
        ob = out_q.size();
        start_frame(2, 2);
        run_frame(2, 2, 0, 4);
        repeat (3) tick();
        check("mid_new_count", DATA_W'(out_q.size() - ob), DATA_W'(1));
        if (out_q.size() > ob) check("mid_new_data", out_q[ob], splat(9));

        // Back-to-back 2x2 frames
        ob = out_q.size(); db = done_cnt;
        start_frame(2, 2);
        run_frame(2, 3, 0, 4);
        for (int t = 0; t < 10 && !o_done; t++) tick();
        check("b2b_done1_seen", DATA_W'(o_done), DATA_W'(1));
        tick();
        start_frame(2, 2);
        run_frame(2, 4, 0, 4);
        repeat (3) tick();
        check("b2b_count", DATA_W'(out_q.size() - ob), DATA_W'(2));
        check("b2b_donecnt", DATA_W'(done_cnt - db), DATA_W'(2));
        if (out_q.size() > ob)     check("b2b_data0", out_q[ob], splat(3));
        if (out_q.size() > ob + 1) check("b2b_data1", out_q[ob+1], splat(40));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
